order_book_update_arbiter: RTL and testbench
============================================

// Module: order_book_update_arbiter
// PURPOSE
//   Round-robin arbiter that shares one order-book update port between N_SRC feed decoders.
//   It accepts at most one decoded update per grant through per-source valid/ready handshakes.
//   It drives the order book's symbol/price/quantity/side/update_valid inputs from a register stage.
//   After each issued update it enforces a programmable idle gap so the book's top-of-book outputs settle.
// PARAMETERS
//   N_SRC       4   number of requesting feed sources (2..8)
//   GAP_CYCLES  1   idle cycles forced after each issued update (0..15; 0 = back-to-back)
//   CNT_W       32  width of statistics counters
// PORTS
//   clk              in   1          system clock
//   rst              in   1          synchronous reset, active-high
//   src_valid        in   N_SRC      per-source update request
//   src_ready        out  N_SRC      per-source accept, one-hot or zero, combinational
//   src_symbol       in   N_SRC*64   source i symbol at [64*i +: 64]
//   src_price        in   N_SRC*32   source i price at [32*i +: 32]
//   src_qty          in   N_SRC*32   source i quantity at [32*i +: 32]
//   src_side         in   N_SRC*8    source i side at [8*i +: 8] (0 = buy, else sell)
//   book_pause       in   1          downstream hold: no grants while high
//   ob_symbol        out  64         to order book symbol
//   ob_price         out  32         to order book price
//   ob_quantity      out  32         to order book quantity
//   ob_side          out  8          to order book side
//   ob_update_valid  out  1          to order book update_valid, single-cycle pulse
//   last_grant       out  $clog2(N_SRC)  index of most recently accepted source
//   grant_count      out  CNT_W      accepted updates, saturating
//   stall_count      out  CNT_W      cycles with any src_valid but no accept, saturating
// BEHAVIOUR
//   Interface
//   - One clock (clk); reset rst is synchronous and active-high.
//   Reset
//   - All ob_* outputs, grant_count and stall_count reset to 0.
//   - last_grant resets to N_SRC-1, so src0 has top priority first.
//   - FSM resets to IDLE with the gap counter at 0.
//   FSM
//   - IDLE: grants allowed.
//     On a handshake: go to GAP with gcnt=GAP_CYCLES if GAP_CYCLES>0, else stay in IDLE.
//   - GAP: no grants; gcnt decrements every cycle, including while book_pause is high.
//     At gcnt==1 go to IDLE on the next cycle.
//   Grant
//   - src_ready[i] = (state==IDLE) & !book_pause & src_valid[i] & (i is the round-robin winner).
//   - Round-robin search starts at (last_grant+1) mod N_SRC and wraps.
//   - Handshake = src_valid[i] & src_ready[i]; at most one per cycle.
//   - Sources hold valid and data stable until accepted. Updates are never dropped or reordered per source.
//   Issue
//   - A handshake at cycle T registers the winner's fields into ob_* and updates last_grant.
//   - ob_update_valid=1 during T+1 only; latency is 1 cycle.
//   - ob_* data holds its last value while ob_update_valid is 0. Side is passed through unmodified.
//   - The next handshake can occur no earlier than T+1+GAP_CYCLES.
//   Counters (both saturate at 2^CNT_W-1; no wrap)
//   - grant_count: +1 per handshake.
//   - stall_count: +1 per cycle with |src_valid and no handshake (pause, gap).
//   Boundary conditions
//   - book_pause rising while a pulse is already registered: the pulse still issues.
//   - A single requester wins regardless of last_grant, including a requester at index last_grant.
//   - Reset mid-operation: a pending ob_update_valid pulse is suppressed and the gap is aborted.
//     Unaccepted source requests remain the sources' responsibility.
// TESTING
//   1. Reset; src0 valid price=100 qty=5 side=0 at cyc 2 -> src_ready[0]=1 cyc 2;
//      ob_update_valid=1 cyc 3 with ob_price=100, ob_quantity=5; grant_count=1.
//   2. GAP_CYCLES=0, all 4 valid continuously -> grants 0,1,2,3,0 on consecutive cycles;
//      ob_update_valid high every cycle.
//   3. GAP_CYCLES=2, src1 and src3 valid -> handshakes at T and T+3; src_ready all 0 at T+1 and T+2.
//   4. book_pause high 5 cycles with src1 valid -> no src_ready; stall_count=5; grant on the first
//      cycle after release.
//   5. Handshake at T, rst=1 at T+1 -> ob_update_valid=0 at T+1..T+2; last_grant=N_SRC-1;
//      grant_count=0.
//   6. last_grant=2, only src2 valid -> src2 granted (wrap); counters preloaded at max stay at max.

Source files
------------

// File: rtl/order_book_update_arbiter.sv
// Round-robin arbiter sharing one order-book update port among N_SRC feed decoders.
// Latency 1 cycle handshake-to-update; no grants during book_pause or the post-update gap.
module order_book_update_arbiter #(
  parameter int N_SRC      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_valid,
  output logic [N_SRC-1:0]         src_ready,
  input  logic [N_SRC*64-1:0]      src_symbol,
  input  logic [N_SRC*32-1:0]      src_price,
  input  logic [N_SRC*32-1:0]      src_qty,
  input  logic [N_SRC*8-1:0]       src_side,
  input  logic                     book_pause,
  output logic [63:0]              ob_symbol,
  output logic [31:0]              ob_price,
  output logic [31:0]              ob_quantity,
  output logic [7:0]               ob_side,
  output logic                     ob_update_valid,
  output logic [$clog2(N_SRC)-1:0] last_grant,
  output logic [CNT_W-1:0]         grant_count,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic {
    IDLE,
    GAP
  } state_t;

  state_t           state;
  logic [3:0]       gcnt;
  logic             uv_q;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             grant_ok;

  logic [63:0] sym_a   [N_SRC];
  logic [31:0] price_a [N_SRC];
  logic [31:0] qty_a   [N_SRC];
  logic [7:0]  side_a  [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign sym_a[i]   = src_symbol[64*i +: 64];
    assign price_a[i] = src_price[32*i +: 32];
    assign qty_a[i]   = src_qty[32*i +: 32];
    assign side_a[i]  = src_side[8*i +: 8];
  end

  // Search starts just after the previous winner and wraps, so the previous
  // winner is considered last and still wins when it is the only requester.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(last_grant) + k) % N_SRC);
      if (!win_vld && src_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign grant_ok  = (state == IDLE) && !book_pause && !rst && win_vld;
  assign src_ready = grant_ok ? (N_SRC'(1) << win_idx) : '0;

  // Gating with rst kills a pulse registered in the cycle before reset.
  assign ob_update_valid = uv_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gcnt        <= '0;
      uv_q        <= 1'b0;
      ob_symbol   <= '0;
      ob_price    <= '0;
      ob_quantity <= '0;
      ob_side     <= '0;
      last_grant  <= IDX_W'(N_SRC - 1);
      grant_count <= '0;
      stall_count <= '0;
    end else begin
      uv_q <= grant_ok;
      if (grant_ok) begin
        ob_symbol   <= sym_a[win_idx];
        ob_price    <= price_a[win_idx];
        ob_quantity <= qty_a[win_idx];
        ob_side     <= side_a[win_idx];
        last_grant  <= win_idx;
        if (grant_count != '1) grant_count <= grant_count + CNT_W'(1);
      end
      if (|src_valid && !grant_ok && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (grant_ok && GAP_CYCLES > 0) begin
            state <= GAP;
            gcnt  <= 4'(GAP_CYCLES);
          end
        end
        GAP: begin
          // Counts down regardless of book_pause.
          if (gcnt <= 4'd1) begin
            state <= IDLE;
            gcnt  <= '0;
          end else begin
            gcnt <= gcnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_book_update_arbiter.sv
// Directed bench: three instances (gap 1, gap 0, gap 2 with 2-bit counters) share one stimulus.
module tb_order_book_update_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   src_valid = '0;
  logic [255:0] src_symbol = '0;
  logic [127:0] src_price = '0;
  logic [127:0] src_qty = '0;
  logic [31:0]  src_side = '0;
  logic         book_pause = 1'b0;

  logic [3:0]  a_ready, b_ready, c_ready;
  logic [63:0] a_sym, b_sym, c_sym;
  logic [31:0] a_price, b_price, c_price;
  logic [31:0] a_qty, b_qty, c_qty;
  logic [7:0]  a_side, b_side, c_side;
  logic        a_uv, b_uv, c_uv;
  logic [1:0]  a_lg, b_lg, c_lg;
  logic [31:0] a_gc, a_sc, b_gc, b_sc;
  logic [1:0]  c_gc, c_sc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  order_book_update_arbiter #(.N_SRC(4), .GAP_CYCLES(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(a_ready),
    .src_symbol(src_symbol), .src_price(src_price), .src_qty(src_qty), .src_side(src_side),
    .book_pause(book_pause), .ob_symbol(a_sym), .ob_price(a_price), .ob_quantity(a_qty),
    .ob_side(a_side), .ob_update_valid(a_uv), .last_grant(a_lg),
    .grant_count(a_gc), .stall_count(a_sc));

  order_book_update_arbiter #(.N_SRC(4), .GAP_CYCLES(0), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(b_ready),
    .src_symbol(src_symbol), .src_price(src_price), .src_qty(src_qty), .src_side(src_side),
    .book_pause(book_pause), .ob_symbol(b_sym), .ob_price(b_price), .ob_quantity(b_qty),
    .ob_side(b_side), .ob_update_valid(b_uv), .last_grant(b_lg),
    .grant_count(b_gc), .stall_count(b_sc));

  order_book_update_arbiter #(.N_SRC(4), .GAP_CYCLES(2), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(c_ready),
    .src_symbol(src_symbol), .src_price(src_price), .src_qty(src_qty), .src_side(src_side),
    .book_pause(book_pause), .ob_symbol(c_sym), .ob_price(c_price), .ob_quantity(c_qty),
    .ob_side(c_side), .ob_update_valid(c_uv), .last_grant(c_lg),
    .grant_count(c_gc), .stall_count(c_sc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    book_pause = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    #1;
    checks++; if (a_uv !== 1'b0) begin errors++; $display("FAIL reset_uv: got %0h want 0", a_uv); end
    checks++; if (a_price !== 32'd0 || a_sym !== 64'd0) begin errors++; $display("FAIL reset_data: price %0h sym %0h want 0", a_price, a_sym); end
    checks++; if (a_lg !== 2'd3) begin errors++; $display("FAIL reset_last_grant: got %0d want 3", a_lg); end
    checks++; if (a_gc !== 32'd0 || a_sc !== 32'd0) begin errors++; $display("FAIL reset_counts: gc %0d sc %0d want 0 0", a_gc, a_sc); end
    checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", a_ready); end
    tick();
  endtask

  task automatic test_single();
    rst = 1'b0;
    src_symbol[63:0] = 64'h4142_4344_0000_0001;
    src_price[31:0] = 32'd100;
    src_qty[31:0] = 32'd5;
    src_side[7:0] = 8'd0;
    src_valid = 4'b0001;
    #1;
    checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", a_ready); end
    tick();
    src_valid = '0;
    #1;
    checks++; if (a_uv !== 1'b1) begin errors++; $display("FAIL single_uv: got %0h want 1", a_uv); end
    checks++; if (a_price !== 32'd100 || a_qty !== 32'd5 || a_side !== 8'd0) begin errors++; $display("FAIL single_data: price %0d qty %0d side %0d want 100 5 0", a_price, a_qty, a_side); end
    checks++; if (a_sym !== 64'h4142_4344_0000_0001) begin errors++; $display("FAIL single_symbol: got %0h want 4142434400000001", a_sym); end
    checks++; if (a_gc !== 32'd1 || a_lg !== 2'd0) begin errors++; $display("FAIL single_stats: gc %0d lg %0d want 1 0", a_gc, a_lg); end
    tick();
    #1;
    checks++; if (a_uv !== 1'b0 || a_price !== 32'd100) begin errors++; $display("FAIL single_hold: uv %0h price %0d want 0 100", a_uv, a_price); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_price[32*i +: 32] = 32'd1000 + 32'(i);
      src_qty[32*i +: 32] = 32'd10 + 32'(i);
      src_side[8*i +: 8] = 8'(i);
    end
    src_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_r;
      exp_r = 4'b0001 << (i % 4);
      #1;
      checks++; if (b_ready !== exp_r) begin errors++; $display("FAIL b2b_ready%0d: got %b want %b", i, b_ready, exp_r); end
      tick();
      checks++; if (b_uv !== 1'b1 || b_price !== 32'd1000 + 32'(i % 4)) begin errors++; $display("FAIL b2b_issue%0d: uv %0h price %0d want 1 %0d", i, b_uv, b_price, 1000 + i % 4); end
    end
    src_valid = '0;
  endtask

  task automatic test_gap();
    do_reset();
    src_valid = 4'b1010;
    #1;
    checks++; if (c_ready !== 4'b0010) begin errors++; $display("FAIL gap_T: got %b want 0010", c_ready); end
    tick();
    #1;
    checks++; if (c_ready !== 4'b0000) begin errors++; $display("FAIL gap_T1: got %b want 0000", c_ready); end
    tick();
    #1;
    checks++; if (c_ready !== 4'b0000) begin errors++; $display("FAIL gap_T2: got %b want 0000", c_ready); end
    tick();
    #1;
    checks++; if (c_ready !== 4'b1000) begin errors++; $display("FAIL gap_T3: got %b want 1000", c_ready); end
    tick();
    src_valid = '0;
  endtask

  task automatic test_pause();
    do_reset();
    book_pause = 1'b1;
    src_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL pause_ready%0d: got %b want 0000", i, a_ready); end
      tick();
    end
    book_pause = 1'b0;
    #1;
    checks++; if (a_sc !== 32'd5) begin errors++; $display("FAIL pause_stall: got %0d want 5", a_sc); end
    checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL pause_release: got %b want 0010", a_ready); end
    tick();
    book_pause = 1'b1;
    src_valid = '0;
    #1;
    checks++; if (a_uv !== 1'b1 || a_lg !== 2'd1) begin errors++; $display("FAIL pause_pulse: uv %0h lg %0d want 1 1", a_uv, a_lg); end
    checks++; if (a_gc !== 32'd1) begin errors++; $display("FAIL pause_gc: got %0d want 1", a_gc); end
    tick();
    book_pause = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_valid = 4'b0001;
    #1;
    checks++; if (a_ready !== 4'b0001 || c_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_hs: a %b c %b want 0001 0001", a_ready, c_ready); end
    tick();
    rst = 1'b1;
    src_valid = '0;
    #1;
    checks++; if (a_uv !== 1'b0) begin errors++; $display("FAIL rstmid_T1: got %0h want 0", a_uv); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (a_uv !== 1'b0) begin errors++; $display("FAIL rstmid_T2: got %0h want 0", a_uv); end
    checks++; if (a_lg !== 2'd3 || a_gc !== 32'd0) begin errors++; $display("FAIL rstmid_state: lg %0d gc %0d want 3 0", a_lg, a_gc); end
    src_valid = 4'b0100;
    #1;
    checks++; if (c_ready !== 4'b0100) begin errors++; $display("FAIL rstmid_gap_abort: got %b want 0100", c_ready); end
    tick();
    src_valid = '0;
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    src_valid = 4'b0111;
    #1;
    checks++; if (c_ready !== 4'b0001) begin errors++; $display("FAIL wrap_C0: got %b want 0001", c_ready); end
    repeat (3) tick();
    checks++; if (c_ready !== 4'b0010) begin errors++; $display("FAIL wrap_C3: got %b want 0010", c_ready); end
    repeat (3) tick();
    checks++; if (c_ready !== 4'b0100) begin errors++; $display("FAIL wrap_C6: got %b want 0100", c_ready); end
    tick();
    src_valid = 4'b0100;
    #1;
    checks++; if (c_lg !== 2'd2 || c_gc !== 2'd3) begin errors++; $display("FAIL wrap_pre: lg %0d gc %0d want 2 3", c_lg, c_gc); end
    tick();
    tick();
    #1;
    checks++; if (c_ready !== 4'b0100) begin errors++; $display("FAIL wrap_self: got %b want 0100", c_ready); end
    tick();
    src_valid = '0;
    #1;
    checks++; if (c_uv !== 1'b1 || c_lg !== 2'd2) begin errors++; $display("FAIL wrap_issue: uv %0h lg %0d want 1 2", c_uv, c_lg); end
    checks++; if (c_gc !== 2'd3 || c_sc !== 2'd3) begin errors++; $display("FAIL sat_counts: gc %0d sc %0d want 3 3", c_gc, c_sc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_pause();
    test_reset_mid();
    test_wrap_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
